// File: rtl/tpu_op_sequencer.sv
// tpu_op_sequencer
// Expands one decoded macro-command (LOAD_WEIGHT, LOAD_INPUTS, COMPUTE,
// STORE, NO_OP) into cycle-by-cycle unified-buffer, array-buffer and
// compute-enable strobes. Every output comes straight from a flop: the
// output values for the coming cycle are decoded from the next state and
// next counter value, then registered together with the state.
module tpu_op_sequencer #(
    parameter int N              = 2,
    parameter int ADDR_W         = 13,
    parameter int COMPUTE_CYCLES = 3*N-2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [ADDR_W-1:0]    cmd_addr,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_rd_addr,
    output logic                 mem_wr_en,
    output logic [ADDR_W-1:0]    mem_wr_addr,
    output logic                 weight_we,
    output logic                 input_we,
    output logic [$clog2(N)-1:0] weight_row,
    output logic [$clog2(N)-1:0] result_row,
    output logic                 array_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int ROW_W = $clog2(N);
    localparam int MAX_K = (COMPUTE_CYCLES > N+1) ? COMPUTE_CYCLES : N+1;
    localparam int CNT_W = $clog2(MAX_K+1);

    localparam logic [CNT_W-1:0] K_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] K_TWO      = CNT_W'(2);
    localparam logic [CNT_W-1:0] K_N        = CNT_W'(N);
    localparam logic [CNT_W-1:0] K_LOAD_END = CNT_W'(N+1);
    localparam logic [CNT_W-1:0] K_CMP_END  = CNT_W'(COMPUTE_CYCLES);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDW = 3'b010;
    localparam logic [2:0] OP_LDI = 3'b011;
    localparam logic [2:0] OP_CMP = 3'b100;
    localparam logic [2:0] OP_STR = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_STORE,
        S_FIN,
        S_ERR
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [2:0]          op_q, op_n;
    logic [ADDR_W-1:0]   base_q, base_n;

    logic                cmd_ready_d;
    logic                mem_rd_en_d;
    logic [ADDR_W-1:0]   mem_rd_addr_d;
    logic                mem_wr_en_d;
    logic [ADDR_W-1:0]   mem_wr_addr_d;
    logic                weight_we_d;
    logic                input_we_d;
    logic [ROW_W-1:0]    weight_row_d;
    logic [ROW_W-1:0]    result_row_d;
    logic                array_valid_d;
    logic                busy_d;
    logic                done_d;
    logic                err_d;

    // Next-state logic: cnt holds the 1-based cycle index k within a command.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op_q;
        base_n  = base_q;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_n   = cmd_op;
                    base_n = cmd_addr;
                    cnt_n  = K_ONE;
                    case (cmd_op)
                        OP_LDW, OP_LDI: state_n = S_LOAD;
                        OP_CMP:         state_n = S_COMPUTE;
                        OP_STR:         state_n = S_STORE;
                        OP_NOP:         state_n = S_FIN;
                        default:        state_n = S_ERR;
                    endcase
                end
            end
            S_LOAD: begin
                if (cnt == K_LOAD_END) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + K_ONE;
                end
            end
            S_COMPUTE: begin
                if (cnt == K_CMP_END) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + K_ONE;
                end
            end
            S_STORE: begin
                if (cnt == K_N) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + K_ONE;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Output decode for the coming cycle, taken from the next state/counter.
    always_comb begin
        cmd_ready_d   = 1'b0;
        mem_rd_en_d   = 1'b0;
        mem_rd_addr_d = '0;
        mem_wr_en_d   = 1'b0;
        mem_wr_addr_d = '0;
        weight_we_d   = 1'b0;
        input_we_d    = 1'b0;
        weight_row_d  = '0;
        result_row_d  = '0;
        array_valid_d = 1'b0;
        busy_d        = 1'b1;
        done_d        = 1'b0;
        err_d         = 1'b0;
        case (state_n)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            S_LOAD: begin
                if (cnt_n <= K_N) begin
                    mem_rd_en_d   = 1'b1;
                    mem_rd_addr_d = base_n + ADDR_W'(cnt_n - K_ONE);
                end
                if (cnt_n >= K_TWO) begin
                    if (op_n == OP_LDW) begin
                        weight_we_d = 1'b1;
                    end else begin
                        input_we_d  = 1'b1;
                    end
                    weight_row_d = ROW_W'(cnt_n - K_TWO);
                end
                done_d = (cnt_n == K_LOAD_END);
            end
            S_COMPUTE: begin
                array_valid_d = 1'b1;
                done_d        = (cnt_n == K_CMP_END);
            end
            S_STORE: begin
                mem_wr_en_d   = 1'b1;
                mem_wr_addr_d = base_n + ADDR_W'(cnt_n - K_ONE);
                result_row_d  = ROW_W'(cnt_n - K_ONE);
                done_d        = (cnt_n == K_N);
            end
            S_FIN: begin
                done_d = 1'b1;
            end
            S_ERR: begin
                err_d = 1'b1;
            end
            default: begin
                busy_d = 1'b1;
            end
        endcase
    end

    // State, latched command and registered outputs; reset abandons any command.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_q        <= '0;
            base_q      <= '0;
            cmd_ready   <= 1'b1;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            weight_we   <= 1'b0;
            input_we    <= 1'b0;
            weight_row  <= '0;
            result_row  <= '0;
            array_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            op_q        <= op_n;
            base_q      <= base_n;
            cmd_ready   <= cmd_ready_d;
            mem_rd_en   <= mem_rd_en_d;
            mem_rd_addr <= mem_rd_addr_d;
            mem_wr_en   <= mem_wr_en_d;
            mem_wr_addr <= mem_wr_addr_d;
            weight_we   <= weight_we_d;
            input_we    <= input_we_d;
            weight_row  <= weight_row_d;
            result_row  <= result_row_d;
            array_valid <= array_valid_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
        end
    end

endmodule

// File: tb/tb_tpu_op_sequencer.sv
// Testbench for tpu_op_sequencer (N=2, ADDR_W=13, COMPUTE_CYCLES=4).
// The driver issues commands and pushes hand-computed per-cycle events,
// stamped with the absolute cycle they must appear in, into a scoreboard.
// A monitor on the falling edge pops and compares whenever the DUT shows
// any strobe, done or err.
`timescale 1ns/1ps
module tb_tpu_op_sequencer;

    localparam int N      = 2;
    localparam int ADDR_W = 13;
    localparam int CC     = 3*N-2;
    localparam int ROW_W  = $clog2(N);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDW = 3'b010;
    localparam logic [2:0] OP_LDI = 3'b011;
    localparam logic [2:0] OP_CMP = 3'b100;
    localparam logic [2:0] OP_STR = 3'b101;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = 3'b000;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic              weight_we;
    logic              input_we;
    logic [ROW_W-1:0]  weight_row;
    logic [ROW_W-1:0]  result_row;
    logic              array_valid;
    logic              busy;
    logic              done;
    logic              err;

    tpu_op_sequencer #(
        .N(N),
        .ADDR_W(ADDR_W),
        .COMPUTE_CYCLES(CC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_addr(cmd_addr),
        .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_wr_en(mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .weight_we(weight_we),
        .input_we(input_we),
        .weight_row(weight_row),
        .result_row(result_row),
        .array_valid(array_valid),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              rd;
        logic [ADDR_W-1:0] ra;
        logic              wr;
        logic [ADDR_W-1:0] wa;
        logic              ww;
        logic              iw;
        logic [ROW_W-1:0]  wrow;
        logic [ROW_W-1:0]  rrow;
        logic              av;
        logic              dn;
        logic              er;
    } ev_t;

    typedef struct {
        int  cyc;
        ev_t ev;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   acc_base = 0;
    int   next_ready_cyc = 0;
    logic chk_ready = 1'b0;
    logic mon_en = 1'b0;

    // Free-running cycle counter used to stamp expected events.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushEv(input int k, input ev_t ev);
        exp_t e;
        e.cyc = acc_base + k;
        e.ev  = ev;
        sb.push_back(e);
    endtask

    task automatic expLoad(input int k, input logic rd, input logic [ADDR_W-1:0] ra,
                           input logic ww, input logic iw, input logic [ROW_W-1:0] row, input logic dn);
        pushEv(k, '{rd: rd, ra: ra, wr: 1'b0, wa: '0, ww: ww, iw: iw, wrow: row, rrow: '0,
                    av: 1'b0, dn: dn, er: 1'b0});
    endtask

    task automatic expCompute(input int k, input logic dn);
        pushEv(k, '{rd: 1'b0, ra: '0, wr: 1'b0, wa: '0, ww: 1'b0, iw: 1'b0, wrow: '0, rrow: '0,
                    av: 1'b1, dn: dn, er: 1'b0});
    endtask

    task automatic expStore(input int k, input logic [ADDR_W-1:0] wa, input logic [ROW_W-1:0] row, input logic dn);
        pushEv(k, '{rd: 1'b0, ra: '0, wr: 1'b1, wa: wa, ww: 1'b0, iw: 1'b0, wrow: '0, rrow: row,
                    av: 1'b0, dn: dn, er: 1'b0});
    endtask

    task automatic expFlag(input int k, input logic dn, input logic er);
        pushEv(k, '{rd: 1'b0, ra: '0, wr: 1'b0, wa: '0, ww: 1'b0, iw: 1'b0, wrow: '0, rrow: '0,
                    av: 1'b0, dn: dn, er: er});
    endtask

    // Waits (bounded) for cmd_ready at a falling edge, then offers the command.
    task automatic applyStimulus(input logic [2:0] op, input logic [ADDR_W-1:0] addr);
        int waited = 0;
        while (cmd_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL ready_timeout: cmd_ready stayed %b, expected 1 within 50 cycles", cmd_ready);
        end else if (chk_ready && waited > 0) begin
            checkOutput("ready_cycle", cyc, next_ready_cyc);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        acc_base  = cyc;
    endtask

    // Moves into cycle 1 of the accepted command; scribbles cmd_* to prove it is ignored.
    task automatic afterAccept(input logic hold);
        @(negedge clk);
        checkOutput("busy_c1", busy, 1);
        checkOutput("ready_c1", cmd_ready, 0);
        cmd_valid = hold;
        cmd_op    = 3'b111;
        cmd_addr  = 13'h1ABC;
    endtask

    // Monitor: every cycle with any activity must match the scoreboard head.
    always @(negedge clk) begin
        ev_t  act;
        exp_t e;
        if (mon_en) begin
            act = '{rd: mem_rd_en, ra: mem_rd_addr, wr: mem_wr_en, wa: mem_wr_addr,
                    ww: weight_we, iw: input_we, wrow: weight_row, rrow: result_row,
                    av: array_valid, dn: done, er: err};
            if ((act.rd | act.wr | act.ww | act.iw | act.av | act.dn | act.er) !== 1'b0) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_event: cycle %0d got %h, expected no activity", cyc, act);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.ev !== act) begin
                        n_fail++;
                        $display("[TB] FAIL event: cycle %0d got %h, expected cycle %0d %h", cyc, act, e.cyc, e.ev);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d events pending", sb.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", cmd_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_strobes", {mem_rd_en, mem_wr_en, weight_we, input_we, array_valid}, 0);
        reset  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        $display("[TB] LOAD_WEIGHT 0x010");
        applyStimulus(OP_LDW, 13'h010);
        expLoad(1, 1'b1, 13'h010, 1'b0, 1'b0, 1'b0, 1'b0);
        expLoad(2, 1'b1, 13'h011, 1'b1, 1'b0, 1'b0, 1'b0);
        expLoad(3, 1'b0, 13'h000, 1'b1, 1'b0, 1'b1, 1'b1);
        next_ready_cyc = acc_base + 4;
        chk_ready = 1'b1;
        afterAccept(1'b0);

        $display("[TB] COMPUTE");
        applyStimulus(OP_CMP, 13'h000);
        expCompute(1, 1'b0);
        expCompute(2, 1'b0);
        expCompute(3, 1'b0);
        expCompute(4, 1'b1);
        next_ready_cyc = acc_base + 5;
        afterAccept(1'b0);

        $display("[TB] STORE 0x1FFF wrap");
        applyStimulus(OP_STR, 13'h1FFF);
        expStore(1, 13'h1FFF, 1'b0, 1'b0);
        expStore(2, 13'h0000, 1'b1, 1'b1);
        next_ready_cyc = acc_base + 3;
        afterAccept(1'b0);

        $display("[TB] back-to-back with cmd_valid held");
        applyStimulus(OP_LDI, 13'h100);
        expLoad(1, 1'b1, 13'h100, 1'b0, 1'b0, 1'b0, 1'b0);
        expLoad(2, 1'b1, 13'h101, 1'b0, 1'b1, 1'b0, 1'b0);
        expLoad(3, 1'b0, 13'h000, 1'b0, 1'b1, 1'b1, 1'b1);
        next_ready_cyc = acc_base + 4;
        afterAccept(1'b1);
        applyStimulus(OP_CMP, 13'h055);
        expCompute(1, 1'b0);
        expCompute(2, 1'b0);
        expCompute(3, 1'b0);
        expCompute(4, 1'b1);
        next_ready_cyc = acc_base + 5;
        afterAccept(1'b1);
        applyStimulus(OP_STR, 13'h020);
        expStore(1, 13'h020, 1'b0, 1'b0);
        expStore(2, 13'h021, 1'b1, 1'b1);
        next_ready_cyc = acc_base + 3;
        afterAccept(1'b1);
        applyStimulus(OP_NOP, 13'h000);
        expFlag(1, 1'b1, 1'b0);
        next_ready_cyc = acc_base + 2;
        afterAccept(1'b0);

        $display("[TB] illegal opcodes");
        applyStimulus(3'b111, 13'h030);
        expFlag(1, 1'b0, 1'b1);
        next_ready_cyc = acc_base + 2;
        afterAccept(1'b0);
        @(negedge clk);
        checkOutput("err_idle_ready", cmd_ready, 1);
        checkOutput("err_idle_busy", busy, 0);
        applyStimulus(3'b001, 13'h030);
        expFlag(1, 1'b0, 1'b1);
        next_ready_cyc = acc_base + 2;
        afterAccept(1'b0);

        $display("[TB] reset during COMPUTE");
        applyStimulus(OP_CMP, 13'h000);
        expCompute(1, 1'b0);
        expCompute(2, 1'b0);
        afterAccept(1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_ready", cmd_ready, 1);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_valid", array_valid, 0);
        reset = 1'b1;
        chk_ready = 1'b0;
        applyStimulus(OP_STR, 13'h040);
        expStore(1, 13'h040, 1'b0, 1'b0);
        expStore(2, 13'h041, 1'b1, 1'b1);
        next_ready_cyc = acc_base + 3;
        chk_ready = 1'b1;
        afterAccept(1'b0);

        repeat (8) @(negedge clk);
        checkOutput("final_ready", cmd_ready, 1);
        checkOutput("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
